wb_stage: RTL and testbench

- Writeback pipeline stage. Registers the memory-stage result and drives the register file write port (wr, wrn, wrd) and the R0 side-port (wr0, r0d).
- Generates the per-read-port forwarding selects (reg_forward_1/2) consumed by the register file read ports.
- Keeps a sticky illegal-destination flag and a retired-instruction counter.

---
 rtl/wb_stage.sv | 72 +++++++
 tb/tb_wb_stage.sv | 121 ++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: writeback register driving the register file and R0 write ports,
// forwarding selects, a sticky illegal-destination flag and a retire counter.
module wb_stage #(
  parameter int REG_DATA_WIDTH = 16,
  parameter int REG_NUM_WIDTH = 4,
  parameter int REG_FORWARD_WIDTH = 2,
  parameter int NUM_REG = 16,
  parameter logic [REG_FORWARD_WIDTH-1:0] REG_FORWARD_REG_FILE = 2'b00,
  parameter logic [REG_FORWARD_WIDTH-1:0] REG_FORWARD_WB = 2'b01,
  parameter logic [REG_FORWARD_WIDTH-1:0] REG_FORWARD_R0 = 2'b10,
  parameter int RETIRE_WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_valid,
  input  logic mem_wr,
  input  logic [REG_NUM_WIDTH-1:0] mem_wrn,
  input  logic [REG_DATA_WIDTH-1:0] mem_wrd,
  input  logic mem_wr0,
  input  logic [REG_DATA_WIDTH-1:0] mem_r0d,
  input  logic stall,
  input  logic flush,
  input  logic [REG_NUM_WIDTH-1:0] rn_1,
  input  logic [REG_NUM_WIDTH-1:0] rn_2,
  output logic wr,
  output logic [REG_NUM_WIDTH-1:0] wrn,
  output logic [REG_DATA_WIDTH-1:0] wrd,
  output logic wr0,
  output logic [REG_DATA_WIDTH-1:0] r0d,
  output logic [REG_FORWARD_WIDTH-1:0] reg_forward_1,
  output logic [REG_FORWARD_WIDTH-1:0] reg_forward_2,
  output logic exception,
  output logic [RETIRE_WIDTH-1:0] retired
);
  logic valid_q, done_q, wr_q, wr0_q, legal_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      done_q <= 1'b0;
      wr_q <= 1'b0;
      wr0_q <= 1'b0;
      legal_q <= 1'b0;
      wrn <= '0;
      wrd <= '0;
      r0d <= '0;
      exception <= 1'b0;
      retired <= '0;
    end else begin
      if (valid_q && !done_q) retired <= retired + RETIRE_WIDTH'(1);
      if (valid_q && wr_q && !legal_q) exception <= 1'b1;
      if (!stall) begin
        valid_q <= mem_valid & ~flush;
        done_q <= 1'b0;
        wr_q <= mem_wr;
        wr0_q <= mem_wr0;
        legal_q <= 32'(mem_wrn) < NUM_REG;
        wrn <= mem_wrn;
        wrd <= mem_wrd;
        r0d <= mem_r0d;
      end else begin
        done_q <= done_q | valid_q;
      end
    end
  end
  assign wr = valid_q & wr_q & ~done_q & legal_q;
  assign wr0 = valid_q & wr0_q & ~done_q;
  // R0 wins over a same-cycle write to register 0, as the register file applies it last
  assign reg_forward_1 = (wr0 && rn_1 == '0) ? REG_FORWARD_R0 :
                         (wr && wrn == rn_1) ? REG_FORWARD_WB : REG_FORWARD_REG_FILE;
  assign reg_forward_2 = (wr0 && rn_2 == '0) ? REG_FORWARD_R0 :
                         (wr && wrn == rn_2) ? REG_FORWARD_WB : REG_FORWARD_REG_FILE;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: vector table plus hand sequences for stall, reset and illegal destinations.
module tb_wb_stage;
  logic clk = 1'b0, rst = 1'b1;
  logic mem_valid = 1'b0, mem_wr = 1'b0, mem_wr0 = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [3:0] mem_wrn = '0, rn_1 = '0, rn_2 = '0;
  logic [15:0] mem_wrd = '0, mem_r0d = '0;
  logic wr, wr0, exception, wr_b, wr0_b, exception_b;
  logic [3:0] wrn, wrn_b;
  logic [15:0] wrd, r0d, retired, wrd_b, r0d_b, retired_b;
  logic [1:0] f1, f2, f1_b, f2_b;
  int total = 0, bad = 0;
  int ret_m = 0;
  always #5 clk = ~clk;
  wb_stage dut (.clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_wr(mem_wr), .mem_wrn(mem_wrn),
    .mem_wrd(mem_wrd), .mem_wr0(mem_wr0), .mem_r0d(mem_r0d), .stall(stall), .flush(flush),
    .rn_1(rn_1), .rn_2(rn_2), .wr(wr), .wrn(wrn), .wrd(wrd), .wr0(wr0), .r0d(r0d),
    .reg_forward_1(f1), .reg_forward_2(f2), .exception(exception), .retired(retired));
  wb_stage #(.NUM_REG(12)) dut12 (.clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_wr(mem_wr),
    .mem_wrn(mem_wrn), .mem_wrd(mem_wrd), .mem_wr0(mem_wr0), .mem_r0d(mem_r0d), .stall(stall),
    .flush(flush), .rn_1(rn_1), .rn_2(rn_2), .wr(wr_b), .wrn(wrn_b), .wrd(wrd_b), .wr0(wr0_b),
    .r0d(r0d_b), .reg_forward_1(f1_b), .reg_forward_2(f2_b), .exception(exception_b),
    .retired(retired_b));
  typedef struct {
    logic v, w; logic [3:0] n; logic [15:0] d; logic w0; logic [15:0] d0; logic fl;
    logic [3:0] r1, r2; logic ew, ew0; logic [1:0] ef1, ef2;
  } vec_t;
  typedef struct { logic [3:0] n; logic [15:0] d, d0; } exp_t;
  vec_t vecs[8];
  exp_t q[$];
  exp_t e;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic w, input logic [3:0] n, input logic [15:0] d,
                       input logic w0, input logic [15:0] d0, input logic fl);
    mem_valid = v; mem_wr = w; mem_wrn = n; mem_wrd = d; mem_wr0 = w0; mem_r0d = d0; flush = fl;
  endtask
  initial begin
    vecs[0] = '{1'b1, 1'b1, 4'd3, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 4'd3, 4'd4, 1'b1, 1'b0, 2'b01, 2'b00};
    vecs[1] = '{1'b1, 1'b1, 4'd0, 16'h1111, 1'b1, 16'h2222, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 2'b10, 2'b10};
    vecs[2] = '{1'b1, 1'b1, 4'd5, 16'h5555, 1'b1, 16'h0505, 1'b1, 4'd5, 4'd0, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[3] = '{1'b0, 1'b1, 4'd2, 16'h2020, 1'b0, 16'h0000, 1'b0, 4'd2, 4'd2, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[4] = '{1'b1, 1'b1, 4'd9, 16'h9999, 1'b1, 16'hABCD, 1'b0, 4'd9, 4'd0, 1'b1, 1'b1, 2'b01, 2'b10};
    vecs[5] = '{1'b1, 1'b0, 4'd6, 16'h6666, 1'b1, 16'h0606, 1'b0, 4'd6, 4'd0, 1'b0, 1'b1, 2'b00, 2'b10};
    vecs[6] = '{1'b1, 1'b1, 4'd15, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 4'd15, 4'd15, 1'b1, 1'b0, 2'b01, 2'b01};
    vecs[7] = '{1'b1, 1'b1, 4'd0, 16'h0001, 1'b0, 16'h0000, 1'b0, 4'd0, 4'd1, 1'b1, 1'b0, 2'b01, 2'b00};
    step(); step();
    chk("rst_wr", wr, 0); chk("rst_wr0", wr0, 0); chk("rst_wrd", wrd, 0);
    chk("rst_f1", f1, 0); chk("rst_exc", exception, 0); chk("rst_ret", retired, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].v, vecs[i].w, vecs[i].n, vecs[i].d, vecs[i].w0, vecs[i].d0, vecs[i].fl);
      rn_1 = vecs[i].r1; rn_2 = vecs[i].r2;
      q.push_back('{vecs[i].n, vecs[i].d, vecs[i].d0});
      step();
      e = q.pop_front();
      chk($sformatf("v%0d_wr", i), wr, vecs[i].ew);
      chk($sformatf("v%0d_wr0", i), wr0, vecs[i].ew0);
      chk($sformatf("v%0d_f1", i), f1, vecs[i].ef1);
      chk($sformatf("v%0d_f2", i), f2, vecs[i].ef2);
      chk($sformatf("v%0d_wrn", i), wrn, e.n);
      chk($sformatf("v%0d_wrd", i), wrd, e.d);
      chk($sformatf("v%0d_r0d", i), r0d, e.d0);
      chk($sformatf("v%0d_ret", i), retired, ret_m);
      ret_m += (vecs[i].v & ~vecs[i].fl) ? 1 : 0;
    end
    drive(1'b1, 1'b1, 4'd7, 16'h7777, 1'b0, 16'h0000, 1'b0);
    rn_1 = 4'd7; rn_2 = 4'd1;
    step();
    chk("stall_wr0", wr, 1); chk("stall_fwd", f1, 2'b01); chk("stall_ret0", retired, ret_m);
    ret_m++;
    stall = 1'b1;
    drive(1'b1, 1'b1, 4'd8, 16'hDEAD, 1'b1, 16'hDEAD, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("stall%0d_wr", k), wr, 0);
      chk($sformatf("stall%0d_wr0", k), wr0, 0);
      chk($sformatf("stall%0d_wrd", k), wrd, 16'h7777);
      chk($sformatf("stall%0d_f1", k), f1, 2'b00);
      chk($sformatf("stall%0d_ret", k), retired, ret_m);
    end
    stall = 1'b0;
    drive(1'b0, 1'b1, 4'd8, 16'hDEAD, 1'b0, 16'h0000, 1'b0);
    step();
    chk("unstall_wr", wr, 0); chk("unstall_wrd", wrd, 16'hDEAD); chk("unstall_ret", retired, ret_m);
    drive(1'b1, 1'b1, 4'd5, 16'h1234, 1'b0, 16'h0000, 1'b0);
    step();
    chk("midrst_pre_wr", wr, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_wr", wr, 0); chk("midrst_wrd", wrd, 0); chk("midrst_ret", retired, 0);
    step();
    rst = 1'b0;
    rn_1 = 4'd13; rn_2 = 4'd0;
    drive(1'b1, 1'b1, 4'd13, 16'h1313, 1'b1, 16'h3333, 1'b0);
    step();
    chk("ill_wr", wr_b, 0); chk("ill_wr0", wr0_b, 1); chk("ill_r0d", r0d_b, 16'h3333);
    chk("ill_exc_early", exception_b, 0); chk("ill_f1", f1_b, 2'b00); chk("ill_f2", f2_b, 2'b10);
    chk("legal16_wr", wr, 1);
    drive(1'b1, 1'b1, 4'd1, 16'h0101, 1'b0, 16'h0000, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("ill_exc%0d", k), exception_b, 1);
      chk($sformatf("ill_wr%0d", k), wr_b, 1);
    end
    drive(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    step();
    chk("ill_exc_end", exception_b, 1); chk("ill_ret", retired_b, 11);
    chk("legal16_exc", exception, 0); chk("legal16_ret", retired, 11);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
